gcbp_subimage_line_gen: RTL and testbench

Parametrised gray-code bit-plane (GCBP) line generator. It taps the luma pixel stream feeding the line buffer and extracts one bit plane per pixel. It packs the bits falling inside each of NUM_SUBIMAGES horizontal windows into one SUBIMAGE_WIDTH-bit word per window per line. Words are presented on a valid/ready port to the sub-image BRAM writer. Bit plane, subimage count, geometry and pixel width are configurable; lines are resynchronised by an explicit line-start strobe.

---
 rtl/gcbp_subimage_line_gen_if.sv | 33 +++
 rtl/gcbp_subimage_line_gen.sv | 140 ++++++++++++++
 tb/tb_gcbp_subimage_line_gen.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/gcbp_subimage_line_gen_if.sv
// Pixel-tap and word-output bus of the GCBP sub-image line generator.
// The slave modport is the generator; the master modport is the pixel source and word consumer.
interface gcbp_subimage_line_gen_if #(
    parameter int unsigned PIXEL_WIDTH    = 8,
    parameter int unsigned SUBIMAGE_WIDTH = 128,
    parameter int unsigned NUM_SUBIMAGES  = 4
);
    localparam int unsigned BP_W  = $clog2(PIXEL_WIDTH);
    localparam int unsigned IDX_W = (NUM_SUBIMAGES > 1) ? $clog2(NUM_SUBIMAGES) : 1;

    logic                      i_enable;
    logic                      i_line_start;
    logic [PIXEL_WIDTH-1:0]    i_luma_data;
    logic                      i_luma_data_valid;
    logic [BP_W-1:0]           i_bit_plane;
    logic [SUBIMAGE_WIDTH-1:0] o_gcbp_line;
    logic                      o_gcbp_line_valid;
    logic                      i_gcbp_line_ready;
    logic [IDX_W-1:0]          o_subimage_idx;
    logic                      o_overflow;

    modport slave (
        input  i_enable, i_line_start, i_luma_data, i_luma_data_valid, i_bit_plane,
        input  i_gcbp_line_ready,
        output o_gcbp_line, o_gcbp_line_valid, o_subimage_idx, o_overflow
    );

    modport master (
        output i_enable, i_line_start, i_luma_data, i_luma_data_valid, i_bit_plane,
        output i_gcbp_line_ready,
        input  o_gcbp_line, o_gcbp_line_valid, o_subimage_idx, o_overflow
    );
endinterface

// File: rtl/gcbp_subimage_line_gen.sv
// Extracts one (gray-code or binary) bit plane from the luma stream and packs each window into a word.
// Optional feature: define GCBP_GRAY_CODE_EN for gray-code planes; plain binary planes otherwise.
module gcbp_subimage_line_gen #(
    parameter int unsigned PIXEL_WIDTH     = 8,
    parameter int unsigned SUBIMAGE_WIDTH  = 128,
    parameter int unsigned NUM_SUBIMAGES   = 4,
    parameter int unsigned PIXELS_PER_LINE = 720,
    parameter int unsigned EDGE_GAP        = 41,
    parameter int unsigned INNER_GAP       = 42
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    gcbp_subimage_line_gen_if.slave  bus
);
    localparam int unsigned BP_W   = $clog2(PIXEL_WIDTH);
    localparam int unsigned IDX_W  = (NUM_SUBIMAGES > 1) ? $clog2(NUM_SUBIMAGES) : 1;
    localparam int unsigned CNT_W  = $clog2(PIXELS_PER_LINE + 1);
    localparam int unsigned CAP_W  = (SUBIMAGE_WIDTH > 1) ? $clog2(SUBIMAGE_WIDTH) : 1;
    localparam int unsigned STRIDE = SUBIMAGE_WIDTH + INNER_GAP;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] GAP      = 2'd1;
    localparam logic [1:0] CAPTURE  = 2'd2;
    localparam logic [1:0] LINE_END = 2'd3;

    logic [1:0]                state, state_nx;
    logic [CNT_W-1:0]          pix_cnt;
    logic [IDX_W-1:0]          win;
    logic [CAP_W-1:0]          cap_cnt;
    logic [SUBIMAGE_WIDTH-1:0] shreg;
    logic [BP_W-1:0]           plane;

    logic                      restart_c, pix_c, at_start_c, cap_last_c, last_win_c;
    logic                      shift_c, first_c, done_c, plane_bit_c;
    logic [PIXEL_WIDTH-1:0]    plane_vec_c;
    logic [BP_W-1:0]           plane_in_c;
    logic [SUBIMAGE_WIDTH-1:0] word_c;

    assign restart_c  = bus.i_enable & bus.i_line_start;
    assign pix_c      = bus.i_luma_data_valid & (32'(pix_cnt) < PIXELS_PER_LINE);
    assign at_start_c = 32'(pix_cnt) == EDGE_GAP + 32'(win) * STRIDE;
    assign cap_last_c = 32'(cap_cnt) == SUBIMAGE_WIDTH - 1;
    assign last_win_c = 32'(win) == NUM_SUBIMAGES - 1;
    assign plane_in_c = (32'(bus.i_bit_plane) >= PIXEL_WIDTH) ? BP_W'(PIXEL_WIDTH - 1)
                                                             : bus.i_bit_plane;

    // Gray bit k is y[k]^y[k+1]; shifting in a zero makes the top plane plain y[MSB].
`ifdef GCBP_GRAY_CODE_EN
    assign plane_vec_c = bus.i_luma_data ^ (bus.i_luma_data >> 1);
`else
    assign plane_vec_c = bus.i_luma_data;
`endif
    assign plane_bit_c = plane_vec_c[plane];
    assign word_c      = {shreg[SUBIMAGE_WIDTH-2:0], plane_bit_c};

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state <= IDLE;
        else         state <= state_nx;
    end

    // Next state and per-beat strobes; restart outranks any pixel in the same cycle.
    always_comb begin
        state_nx = state;
        shift_c  = 1'b0;
        first_c  = 1'b0;
        done_c   = 1'b0;
        if (!bus.i_enable) begin
            state_nx = IDLE;
        end else if (bus.i_line_start) begin
            state_nx = GAP;
        end else begin
            case (state)
                GAP: begin
                    if (pix_c && at_start_c) begin
                        shift_c  = 1'b1;
                        first_c  = 1'b1;
                        state_nx = CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (pix_c) begin
                        shift_c = 1'b1;
                        if (cap_last_c) begin
                            done_c   = 1'b1;
                            state_nx = last_win_c ? LINE_END : GAP;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Line position, capture shifter and latched plane.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pix_cnt <= '0;
            win     <= '0;
            cap_cnt <= '0;
            shreg   <= '0;
            plane   <= '0;
        end else if (restart_c) begin
            pix_cnt <= '0;
            win     <= '0;
            cap_cnt <= '0;
            plane   <= plane_in_c;
        end else begin
            if (state != IDLE && bus.i_enable && pix_c)
                pix_cnt <= pix_cnt + CNT_W'(1);
            if (shift_c)
                shreg <= word_c;
            if (first_c)
                cap_cnt <= CAP_W'(1);
            else if (shift_c)
                cap_cnt <= done_c ? '0 : cap_cnt + CAP_W'(1);
            if (done_c && !last_win_c)
                win <= win + IDX_W'(1);
        end
    end

    // Single-entry output holding register; a completion while the consumer stalls is dropped.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            bus.o_gcbp_line       <= '0;
            bus.o_gcbp_line_valid <= 1'b0;
            bus.o_subimage_idx    <= '0;
            bus.o_overflow        <= 1'b0;
        end else if (done_c) begin
            if (!bus.o_gcbp_line_valid || bus.i_gcbp_line_ready) begin
                bus.o_gcbp_line       <= word_c;
                bus.o_subimage_idx    <= win;
                bus.o_gcbp_line_valid <= 1'b1;
            end else begin
                bus.o_overflow <= 1'b1;
            end
        end else if (bus.o_gcbp_line_valid && bus.i_gcbp_line_ready) begin
            bus.o_gcbp_line_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_gcbp_subimage_line_gen.sv
// Scoreboard bench for gcbp_subimage_line_gen: the driver queues hand-computed words, a monitor checks them.
module tb_gcbp_subimage_line_gen;
    localparam int unsigned SW    = 128;
    localparam int unsigned IDX_W = 2;
    localparam int LAST_P [4] = '{168, 338, 508, 678};

    typedef struct {
        logic [IDX_W-1:0] idx;
        logic [SW-1:0]    word;
        int               when;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t q[$];
    exp_t e;
    logic [SW-1:0] expw [4];
    logic [SW-1:0] ones;
    logic          probe;

    gcbp_subimage_line_gen_if #(.PIXEL_WIDTH(8), .SUBIMAGE_WIDTH(SW), .NUM_SUBIMAGES(4)) bus ();

    gcbp_subimage_line_gen dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every accepted word must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && bus.o_gcbp_line_valid && bus.i_gcbp_line_ready) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word idx=%0d data=%h cyc=%0d required no word",
                         bus.o_subimage_idx, bus.o_gcbp_line, cyc);
            end else begin
                e = q.pop_front();
                if (bus.o_subimage_idx !== e.idx || bus.o_gcbp_line !== e.word ||
                    (e.when >= 0 && cyc != e.when)) begin
                    errors++;
                    $display("FAIL word got idx=%0d data=%h cyc=%0d required idx=%0d data=%h cyc=%0d",
                             bus.o_subimage_idx, bus.o_gcbp_line, cyc, e.idx, e.word, e.when);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [SW-1:0] got, input logic [SW-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h required=%h", name, got, want);
        end
    endtask

    function automatic logic [7:0] luma_of(input int pat, input int p);
        case (pat)
            0:       return (p >= 41 && p <= 168) ? 8'h10 : 8'h00;
            1:       return 8'h30;
            2:       return 8'h10;
            3:       return (p == 41) ? 8'h10 : 8'h00;
            4:       return (p == 168) ? 8'h10 : 8'h00;
            default: return 8'h00;
        endcase
    endfunction

    // One line: line_start beat (carrying a junk pixel), then pixels 0..719 up to abort_p.
    task automatic drive_line(input int pat, input logic [3:0] mask, input bit timed,
                              input int abort_p, input bit gaps, input int probe_p);
        bus.i_line_start      = 1'b1;
        bus.i_luma_data_valid = 1'b1;
        bus.i_luma_data       = 8'hFF;
        bus.i_bit_plane       = 3'd4;
        tick();
        bus.i_line_start = 1'b0;
        bus.i_bit_plane  = 3'd7;
        for (int p = 0; p < 720; p++) begin
            if (p == abort_p) break;
            if (p == probe_p) probe = bus.o_overflow;
            bus.i_luma_data       = luma_of(pat, p);
            bus.i_luma_data_valid = 1'b1;
            for (int w = 0; w < 4; w++)
                if (p == LAST_P[w] && mask[w])
                    q.push_back('{IDX_W'(w), expw[w], timed ? cyc + 1 : -1});
            tick();
            if (gaps) begin
                bus.i_luma_data_valid = 1'b0;
                bus.i_luma_data       = 8'hFF;
                tick();
            end
        end
        bus.i_luma_data_valid = 1'b0;
    endtask

    initial begin
        ones = '1;
        probe = 1'b1;
        rst = 1'b1;
        bus.i_enable          = 1'b1;
        bus.i_line_start      = 1'b0;
        bus.i_luma_data       = '0;
        bus.i_luma_data_valid = 1'b0;
        bus.i_bit_plane       = '0;
        bus.i_gcbp_line_ready = 1'b1;
        repeat (3) tick();
        chk("reset_valid", SW'(bus.o_gcbp_line_valid), '0);
        chk("reset_line", bus.o_gcbp_line, '0);
        chk("reset_idx", SW'(bus.o_subimage_idx), '0);
        chk("reset_overflow", SW'(bus.o_overflow), '0);
        rst = 1'b0;
        tick();

        // Window 0 all ones, others zero; words one cycle after p=168,338,508,678.
        expw = '{ones, '0, '0, '0};
        drive_line(0, 4'hF, 1'b1, -1, 1'b0, -1);
        repeat (5) tick();

`ifdef GCBP_GRAY_CODE_EN
        expw = '{'0, '0, '0, '0};
`else
        expw = '{ones, ones, ones, ones};
`endif
        drive_line(1, 4'hF, 1'b1, -1, 1'b0, -1);
        expw = '{ones, ones, ones, ones};
        drive_line(2, 4'hF, 1'b1, -1, 1'b0, -1);

        // Bit ordering: first window pixel lands in the MSB, last in the LSB.
        expw = '{{1'b1, 127'b0}, '0, '0, '0};
        drive_line(3, 4'hF, 1'b1, -1, 1'b0, -1);
        expw = '{128'd1, '0, '0, '0};
        drive_line(4, 4'hF, 1'b1, -1, 1'b0, -1);
        repeat (5) tick();

        // Stalled consumer: word 0 stays, later words dropped and overflow sticks.
        bus.i_gcbp_line_ready = 1'b0;
        expw = '{ones, '0, '0, '0};
        drive_line(0, 4'h0, 1'b0, -1, 1'b0, 300);
        repeat (3) tick();
        chk("overflow_before_p338", SW'(probe), '0);
        chk("stall_overflow", SW'(bus.o_overflow), SW'(1));
        chk("stall_valid", SW'(bus.o_gcbp_line_valid), SW'(1));
        chk("stall_idx", SW'(bus.o_subimage_idx), '0);
        chk("stall_line", bus.o_gcbp_line, ones);
        q.push_back('{IDX_W'(0), ones, -1});
        bus.i_gcbp_line_ready = 1'b1;
        tick();
        tick();
        chk("accept_valid_drop", SW'(bus.o_gcbp_line_valid), '0);

        // Restart at p=100 mid-window: no word for the aborted window, then a normal line.
        expw = '{ones, ones, ones, ones};
        drive_line(2, 4'h0, 1'b0, 100, 1'b0, -1);
        drive_line(2, 4'hF, 1'b1, -1, 1'b0, -1);
        repeat (5) tick();

        // Async reset mid-capture with 1-0-1 valid pattern clears outputs at once.
        drive_line(2, 4'h0, 1'b0, 100, 1'b1, -1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", SW'(bus.o_gcbp_line_valid), '0);
        chk("async_rst_line", bus.o_gcbp_line, '0);
        chk("async_rst_idx", SW'(bus.o_subimage_idx), '0);
        chk("async_rst_overflow", SW'(bus.o_overflow), '0);
        tick();
        rst = 1'b0;
        tick();
        expw = '{ones, '0, '0, '0};
        drive_line(0, 4'hF, 1'b1, -1, 1'b1, -1);
        repeat (20) tick();

        chk("scoreboard_drained", SW'(q.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
